// File: rtl/radix_digit_converter_pkg.sv
// Shared definitions for the radix digit converter: state encoding, divisors and nibble width.
package radix_digit_converter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDiv   = 2'd1,
      StStore = 2'd2
   } state_t;

   localparam logic [4:0]  RADIX_DEC_DIVISOR = 5'd10;
   localparam logic [4:0]  RADIX_HEX_DIVISOR = 5'd16;
   localparam int unsigned NIBBLE_W          = 4;

endpackage

// File: rtl/radix_div_step.sv
// One restoring shift-subtract division step: shifts in_bit into the remainder and trial-subtracts.
module radix_div_step (
   input  logic [4:0] rem,
   input  logic       in_bit,
   input  logic [4:0] divisor,
   output logic       q_bit,
   output logic [4:0] rem_next
);

   logic [4:0] shifted;
   // The incoming remainder is always below the divisor, so its MSB never matters.
   logic       unused_rem_msb;

   always_comb begin
      unused_rem_msb = rem[4];
      shifted        = {rem[3:0], in_bit};
      q_bit          = (shifted >= divisor);
      rem_next       = q_bit ? (shifted - divisor) : shifted;
   end

endmodule

// File: rtl/radix_digit_converter.sv
// Sequential binary-to-digit converter: repeated long division by 10 or 16, one quotient bit
// per cycle, with all display outputs published together on the final store.
module radix_digit_converter
   import radix_digit_converter_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [WIDTH-1:0]             value,
   input  logic                         radix_dec,
   output logic                         busy,
   output logic                         done,
   output logic [NIBBLE_W*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]            blank,
   output logic                         overflow
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DigW = NIBBLE_W * DIGITS;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    quot_q, quot_d;
   logic [4:0]          rem_q, rem_d;
   logic [4:0]          divisor_q, divisor_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic                dec_q, dec_d;
   logic [DigW-1:0]     work_q, work_d;
   logic [DigW-1:0]     digits_q, digits_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;

   logic                step_q_bit;
   logic [4:0]          step_rem;

   // Blank every leading zero digit above the first non-zero one; digit 0 is always shown.
   function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [DigW-1:0] d);
      logic              seen;
      logic [DIGITS-1:0] mask;
      seen = 1'b0;
      mask = '0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         if (d[i*NIBBLE_W +: NIBBLE_W] != '0) seen = 1'b1;
         mask[i] = ~seen;
      end
      return mask;
   endfunction

   radix_div_step u_div_step (
      .rem      (rem_q),
      .in_bit   (quot_q[WIDTH-1]),
      .divisor  (divisor_q),
      .q_bit    (step_q_bit),
      .rem_next (step_rem)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StDiv;
         StDiv:   if (cnt_q == '0) state_d = StStore;
         StStore: state_d = (idx_q == IdxW'(DIGITS - 1)) ? StIdle : StDiv;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      quot_d    = quot_q;
      rem_d     = rem_q;
      divisor_d = divisor_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      dec_d     = dec_q;
      work_d    = work_q;
      digits_d  = digits_q;
      blank_d   = blank_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               quot_d    = value;
               divisor_d = radix_dec ? RADIX_DEC_DIVISOR : RADIX_HEX_DIVISOR;
               dec_d     = radix_dec;
               rem_d     = '0;
               cnt_d     = CntW'(WIDTH - 1);
               idx_d     = '0;
            end
         end
         StDiv: begin
            quot_d = {quot_q[WIDTH-2:0], step_q_bit};
            rem_d  = step_rem;
            cnt_d  = cnt_q - 1'b1;
         end
         StStore: begin
            work_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = rem_q[NIBBLE_W-1:0];
            rem_d = '0;
            cnt_d = CntW'(WIDTH - 1);
            if (idx_q == IdxW'(DIGITS - 1)) begin
               digits_d = work_d;
               blank_d  = lead_zero_mask(work_d);
               ovf_d    = dec_q && (quot_q != '0);
               done_d   = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quot_q    <= '0;
         rem_q     <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         dec_q     <= 1'b0;
         work_q    <= '0;
         digits_q  <= '0;
         blank_q   <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         divisor_q <= divisor_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         dec_q     <= dec_d;
         work_q    <= work_d;
         digits_q  <= digits_d;
         blank_q   <= blank_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      busy     = (state_q != StIdle);
      done     = done_q;
      digits   = digits_q;
      blank    = blank_q;
      overflow = ovf_q;
   end

endmodule

// File: tb/tb_radix_digit_converter.sv
// Self-checking bench for radix_digit_converter: vector table, random values against an
// arithmetic reference model, and hand-written multi-cycle sequences.
module tb_radix_digit_converter;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] value;
   logic        radix_dec;
   logic        busy;
   logic        done;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        overflow;

   int n_vec;
   int n_miss;

   radix_digit_converter #(
      .WIDTH  (16),
      .DIGITS (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .value     (value),
      .radix_dec (radix_dec),
      .busy      (busy),
      .done      (done),
      .digits    (digits),
      .blank     (blank),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] v;
      logic        dec;
      logic [15:0] exp_digits;
      logic [3:0]  exp_blank;
      logic        exp_ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain repeated division, digits packed one per nibble.
   task automatic ref_model(input logic [15:0] v, input logic dec, output logic [15:0] d,
                            output logic [3:0] b, output logic o);
      int unsigned base;
      int unsigned m;
      int unsigned dg [4];
      bit          nz;
      base = dec ? 10 : 16;
      m    = v;
      for (int i = 0; i < 4; i++) begin
         dg[i] = m % base;
         m     = m / base;
      end
      o  = dec && (m != 0);
      d  = {dg[3][3:0], dg[2][3:0], dg[1][3:0], dg[0][3:0]};
      b  = 4'b0000;
      nz = 1'b0;
      for (int i = 3; i >= 1; i--) begin
         if (dg[i] != 0) nz = 1'b1;
         b[i] = !nz;
      end
   endtask

   task automatic convert(input logic [15:0] v, input logic dec, input logic [15:0] ed,
                          input logic [3:0] eb, input logic eo, input string tag);
      int lat;
      @(negedge clk);
      value     = v;
      radix_dec = dec;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      value     = 16'($urandom);
      radix_dec = 1'($urandom);
      check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'd68);
      check({tag, " digits"}, 32'(digits), 32'(ed));
      check({tag, " blank"}, 32'(blank), 32'(eb));
      check({tag, " overflow"}, 32'(overflow), 32'(eo));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, 32'(done), 32'd0);
   endtask

   initial begin
      vec_t        tbl [10];
      logic [15:0] rd;
      logic [3:0]  rb;
      logic        ro;
      logic [15:0] rv;
      logic        rdec;
      logic [15:0] last_digits;
      int          lat;
      int          lat2;
      bit          flag;

      n_vec  = 0;
      n_miss = 0;
      reset     = 1'b1;
      start     = 1'b0;
      value     = '0;
      radix_dec = 1'b0;

      tbl[0] = '{16'd1234,  1'b1, 16'h1234, 4'b0000, 1'b0};
      tbl[1] = '{16'hBEEF,  1'b0, 16'hBEEF, 4'b0000, 1'b0};
      tbl[2] = '{16'd0,     1'b1, 16'h0000, 4'b1110, 1'b0};
      tbl[3] = '{16'd7,     1'b1, 16'h0007, 4'b1110, 1'b0};
      tbl[4] = '{16'd12345, 1'b1, 16'h2345, 4'b0000, 1'b1};
      tbl[5] = '{16'd9999,  1'b1, 16'h9999, 4'b0000, 1'b0};
      tbl[6] = '{16'd10000, 1'b1, 16'h0000, 4'b1110, 1'b1};
      tbl[7] = '{16'd65535, 1'b1, 16'h5535, 4'b0000, 1'b1};
      tbl[8] = '{16'h00A0,  1'b0, 16'h00A0, 4'b1100, 1'b0};
      tbl[9] = '{16'd100,   1'b1, 16'h0100, 4'b1000, 1'b0};

      repeat (2) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset digits", 32'(digits), 32'd0);
      check("reset blank", 32'(blank), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         convert(tbl[i].v, tbl[i].dec, tbl[i].exp_digits, tbl[i].exp_blank, tbl[i].exp_ovf,
                 $sformatf("table[%0d]", i));
      end

      for (int i = 0; i < 30; i++) begin
         rv   = 16'($urandom_range(0, 65535));
         rdec = 1'($urandom_range(0, 1));
         ref_model(rv, rdec, rd, rb, ro);
         convert(rv, rdec, rd, rb, ro, $sformatf("random %0d dec=%0d", rv, rdec));
      end

      // start pulses during busy must be ignored
      @(negedge clk);
      value     = 16'd1111;
      radix_dec = 1'b1;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = 0;
      flag  = 1'b1;
      while (!done && lat < 200) begin
         if (lat == 10 || lat == 40) begin
            start     = 1'b1;
            value     = 16'd5555;
            radix_dec = 1'b0;
         end else begin
            start = 1'b0;
         end
         if (!busy) flag = 1'b0;
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check("ignore latency", 32'(lat), 32'd68);
      check("ignore busy_continuous", 32'(flag), 32'd1);
      check("ignore digits", 32'(digits), 32'h1111);
      check("ignore overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      check("ignore no_restart", 32'(busy), 32'd0);

      // reset mid-conversion
      value     = 16'd9999;
      radix_dec = 1'b1;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset digits", 32'(digits), 32'd0);
      check("midreset blank", 32'(blank), 32'd0);
      check("midreset overflow", 32'(overflow), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      flag  = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done || busy) flag = 1'b1;
      end
      check("midreset no_done", 32'(flag), 32'd0);
      convert(16'd42, 1'b1, 16'h0042, 4'b1100, 1'b0, "after_reset 42");

      // back-to-back with start held high
      last_digits = 16'h0042;
      @(negedge clk);
      value     = 16'd1;
      radix_dec = 1'b1;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      value = 16'd2;
      lat   = 0;
      flag  = 1'b1;
      while (!done && lat < 200) begin
         if (digits !== last_digits) flag = 1'b0;
         @(negedge clk);
         lat++;
      end
      check("b2b first latency", 32'(lat), 32'd68);
      check("b2b first digits", 32'(digits), 32'h0001);
      last_digits = 16'h0001;
      @(negedge clk);
      lat2 = 1;
      while (!done && lat2 < 200) begin
         if (digits !== last_digits) flag = 1'b0;
         @(negedge clk);
         lat2++;
      end
      start = 1'b0;
      check("b2b done spacing", 32'(lat2), 32'd69);
      check("b2b second digits", 32'(digits), 32'h0002);
      check("b2b digits_stable_between", 32'(flag), 32'd1);

      repeat (80) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/radix_digit_converter.md
# radix_digit_converter

Sequential radix converter that turns a 16-bit binary value into four display digits (decimal or hexadecimal) for the 4-digit 7-segment scan path. It sequences one shift-subtract divider step per cycle, producing one quotient bit each step. Results are published atomically, so the scan logic never shows a half-converted number. It sits between the calculator datapath (value source) and the display multiplexer (digit/blank consumer).

## Interface
- `WIDTH`, 16: input value width; the step counter runs `WIDTH` cycles per digit.
- `DIGITS`, 4: number of output digits, one nibble each.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state and outputs.
- `start` input 1: request a conversion. Sampled only in IDLE.
- `value` input WIDTH: binary value. Sampled on the accepting edge.
- `radix_dec` input 1: 1 selects divisor 10, 0 selects divisor 16. Sampled on the accepting edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when outputs update.
- `digits` output 4*DIGITS: `digits[3:0]` is the least significant digit.
- `blank` output DIGITS: 1 marks a leading-zero digit. Bit 0 is never set.
- `overflow` output 1: set when a decimal value is ≥ 10^DIGITS.

## Operation
- States: IDLE, DIV, STORE.
  - IDLE → DIV on `start`: latch `value` into the quotient register, latch the divisor, clear the 5-bit remainder, set step count to WIDTH-1, set digit index to 0, and set `busy` to 1.
- DIV step, per cycle:
  - `r = {rem[3:0], q[MSB]}`; shift `q` left.
  - If `r >= divisor`: `rem = r - divisor` and the quotient LSB is 1.
  - Otherwise: `rem = r` and the quotient LSB is 0.
  - After WIDTH steps, go to STORE.
- STORE: write `rem[3:0]` into working digit[index]. The quotient becomes the next dividend and the remainder is cleared.
  - If index < DIGITS-1: increment index and return to DIV.
  - Otherwise: go to IDLE and publish.
- Publish, all on one edge:
  - `digits` ← working digits.
  - `blank` ← leading-zero mask, scanning from the MS digit down and stopping at the first non-zero digit. Bit 0 is forced to 0.
  - `overflow` ← `radix_dec` and final quotient ≠ 0.
  - `done` ← 1 and `busy` ← 0.
- Arithmetic widths:
  - Remainder is 5 bits, since the shifted remainder is < 32.
  - Digits hold value mod 10^DIGITS (decimal) or value mod 16^DIGITS (hex).
  - Hex never overflows at WIDTH = 4*DIGITS.
- `start` while busy: ignored, no queueing.
- `value` and `radix_dec` changes during busy: ignored.
- `start` held high: a new conversion is accepted on the first IDLE cycle, which is the edge after `done` rises.
- `reset` mid-conversion: immediate return to IDLE. `busy`, `done`, `overflow`, `digits` and `blank` all go to 0; no partial publish.

## Timing
- Reset values: every output is 0; state is IDLE.
- The accepting edge is E0. `busy` is high from E0.
- Digit d is stored at edge E0 + 17·(d+1).
- With DIGITS=4: publish at E0+68, `done` high for cycle E0+68..E0+69, `busy` low from E0+68.
- Latency = DIGITS·(WIDTH+1) cycles.
- Outputs hold their values between publishes.

## Structure
- Shared package holds:
  - state encoding: IDLE, DIV, STORE;
  - `RADIX_DEC_DIVISOR = 10` and `RADIX_HEX_DIVISOR = 16`;
  - the digit nibble width of 4.
- One sub-module, `radix_div_step`: a combinational single restoring step.
  - Inputs: rem[4:0], in_bit, divisor[4:0].
  - Outputs: q_bit, rem_next[4:0].
  - The controller instantiates it once and reuses it every cycle.

## Test plan
- Decimal 1234, start at E0 → at E0+68: `digits`=16'h1234, `blank`=4'b0000, `overflow`=0, `done` pulses exactly one cycle.
- Hex 16'hBEEF → `digits`=16'hBEEF, `blank`=0000, `overflow`=0. Decimal 0 → `digits`=16'h0000, `blank`=4'b1110.
- Decimal 7 → `digits`=16'h0007, `blank`=4'b1110. Decimal 12345 → `digits`=16'h2345, `overflow`=1, `blank`=0000.
- `start` pulsed at E0+10 and again at E0+40 with a different value → both ignored; result matches the E0 value; `busy` stays continuously high until E0+68.
- Converting 9999 decimal, assert `reset` at E0+30 for one cycle → all outputs 0 immediately; no `done` pulse. A following start of 42 gives `digits`=16'h0042, `blank`=4'b1100.
- Back-to-back with `start` held high: values 1 then 2 → second `done` exactly 69 cycles after the first; `digits` change only on the `done` edges.
